rb_sequencer: RTL

RB_SEQUENCER -- requirements
Module: rb_sequencer

---
 rtl/rb_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rb_sequencer.sv
// rb_sequencer: register-bank/ALU control sequencer with registered outputs.
module rb_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        res,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  in_mux_add,
  output logic        write_en,
  output logic [3:0]  reg_add,
  output logic [7:0]  cu_const,
  output logic [3:0]  out_mux_add,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  output logic        done,
  output logic        err,
  output logic [7:0]  retired
);
  localparam logic [3:0] OP_NOP = 4'd0, OP_LDA = 4'd1, OP_LDB = 4'd2, OP_LDI = 4'd3,
                         OP_MOV = 4'd4, OP_ALU = 4'd5;
  typedef enum logic [2:0] {IDLE, WRITE, MOV_SEL, ALU_ISSUE, ALU_WAIT} state_t;
  state_t      state_q, state_d;
  logic [3:0]  opc_q, opc_d, rd_q, rd_d, cnt_q, cnt_d;
  logic [7:0]  imm_q, imm_d;
  logic        instr_ready_q, instr_ready_d, write_en_q, write_en_d;
  logic        alu_start_q, alu_start_d, done_q, done_d, err_q, err_d;
  logic [2:0]  in_mux_add_q, in_mux_add_d, alu_op_q, alu_op_d;
  logic [3:0]  reg_add_q, reg_add_d, out_mux_add_q, out_mux_add_d;
  logic [7:0]  cu_const_q, cu_const_d, retired_q, retired_d;
  logic        accept;
  assign accept      = instr_valid & instr_ready_q;
  assign instr_ready = instr_ready_q;
  assign in_mux_add  = in_mux_add_q;
  assign write_en    = write_en_q;
  assign reg_add     = reg_add_q;
  assign cu_const    = cu_const_q;
  assign out_mux_add = out_mux_add_q;
  assign alu_op      = alu_op_q;
  assign alu_start   = alu_start_q;
  assign done        = done_q;
  assign err         = err_q;
  assign retired     = retired_q;
  always_comb begin
    state_d       = state_q;
    opc_d         = opc_q;
    rd_d          = rd_q;
    imm_d         = imm_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    done_d        = 1'b0;
    write_en_d    = 1'b0;
    alu_start_d   = 1'b0;
    in_mux_add_d  = in_mux_add_q;
    reg_add_d     = reg_add_q;
    cu_const_d    = cu_const_q;
    out_mux_add_d = out_mux_add_q;
    alu_op_d      = alu_op_q;
    case (state_q)
      IDLE: if (accept) begin
        opc_d = instr[15:12];
        rd_d  = instr[11:8];
        imm_d = instr[7:0];
        case (instr[15:12])
          OP_LDA, OP_LDB, OP_LDI: state_d = WRITE;
          OP_MOV:                 state_d = MOV_SEL;
          OP_ALU:                 state_d = ALU_ISSUE;
          OP_NOP:                 done_d  = 1'b1;
          default:                err_d   = 1'b1;
        endcase
      end
      MOV_SEL: state_d = WRITE;
      // cnt counts the remaining ALU_WAIT cycles after the first one
      ALU_ISSUE: begin
        state_d = (ALU_LAT == 1) ? WRITE : ALU_WAIT;
        cnt_d   = 4'(ALU_LAT - 2);
      end
      ALU_WAIT: begin
        state_d = (cnt_q == 4'd0) ? WRITE : ALU_WAIT;
        cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    // outputs are decoded from the next state so they appear registered with it
    if (state_d == WRITE) begin
      write_en_d    = 1'b1;
      done_d        = 1'b1;
      reg_add_d     = rd_d;
      in_mux_add_d  = (opc_d == OP_LDA) ? 3'b000 :
                      (opc_d == OP_LDB) ? 3'b001 :
                      (opc_d == OP_LDI) ? 3'b010 :
                      (opc_d == OP_MOV) ? 3'b100 : 3'b011;
      cu_const_d    = (opc_d == OP_LDI) ? imm_d : cu_const_q;
      out_mux_add_d = (opc_d == OP_MOV) ? imm_d[7:4] : out_mux_add_q;
    end
    if (state_d == MOV_SEL) out_mux_add_d = imm_d[7:4];
    if (state_d == ALU_ISSUE) begin
      alu_start_d = 1'b1;
      alu_op_d    = imm_d[2:0];
    end
    instr_ready_d = (state_d == IDLE);
    retired_d     = retired_q + 8'(done_d);
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q       <= IDLE;
      opc_q         <= '0;
      rd_q          <= '0;
      imm_q         <= '0;
      cnt_q         <= '0;
      instr_ready_q <= 1'b1;
      in_mux_add_q  <= '0;
      write_en_q    <= 1'b0;
      reg_add_q     <= '0;
      cu_const_q    <= '0;
      out_mux_add_q <= '0;
      alu_op_q      <= '0;
      alu_start_q   <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      opc_q         <= opc_d;
      rd_q          <= rd_d;
      imm_q         <= imm_d;
      cnt_q         <= cnt_d;
      instr_ready_q <= instr_ready_d;
      in_mux_add_q  <= in_mux_add_d;
      write_en_q    <= write_en_d;
      reg_add_q     <= reg_add_d;
      cu_const_q    <= cu_const_d;
      out_mux_add_q <= out_mux_add_d;
      alu_op_q      <= alu_op_d;
      alu_start_q   <= alu_start_d;
      done_q        <= done_d;
      err_q         <= err_d;
      retired_q     <= retired_d;
    end
  end
endmodule
